// File: rtl/fabric_bitstream_checker.sv
// Bitstream framing/integrity stage: sync hunt, length header, payload forwarding, optional CRC32.
// Optional trailing CRC32 check is enabled by defining BITSTREAM_CRC_EN.
module fabric_bitstream_checker #(
    parameter logic [31:0] SYNC_WORD = 32'hFAB0_FAB1,
    parameter logic [15:0] HDR_MAGIC = 16'hB57C,
    parameter logic [15:0] MAX_WORDS = 16'd3746
) (
    input  logic        fpga_clk_i,
    input  logic        fpga_rst_ni,
    input  logic        clear_i,
    input  logic [31:0] data_i,
    input  logic        valid_i,
    output logic [31:0] data_o,
    output logic        valid_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [1:0]  error_code_o
);

    typedef enum logic [2:0] {
        S_HUNT,
        S_HEADER,
        S_PAYLOAD,
`ifdef BITSTREAM_CRC_EN
        S_CRC,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_MAGIC = 2'd1;
    localparam logic [1:0] ERR_LEN   = 2'd2;

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  code_q, code_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        busy_q, done_q, error_q;
    logic        last_word;

`ifdef BITSTREAM_CRC_EN
    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [1:0]  ERR_CRC  = 2'd3;

    logic [31:0] crc_q, crc_d;

    // Folds one whole word per cycle, data bit 31 entering first.
    function automatic logic [31:0] crc_fold(
        input logic [31:0] crc,
        input logic [31:0] word
    );
        logic [31:0] r;
        r = crc;
        for (int i = 31; i >= 0; i--) begin
            if (r[31] ^ word[i]) r = (r << 1) ^ CRC_POLY;
            else                 r = r << 1;
        end
        return r;
    endfunction
`endif

    assign last_word = (cnt_q == len_q - 16'd1);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        data_d  = data_q;
        valid_d = 1'b0;
`ifdef BITSTREAM_CRC_EN
        crc_d   = crc_q;
`endif
        if (clear_i) begin
            state_d = S_HUNT;
            len_d   = 16'd0;
            cnt_d   = 16'd0;
            code_d  = ERR_NONE;
            data_d  = 32'd0;
`ifdef BITSTREAM_CRC_EN
            crc_d   = CRC_INIT;
`endif
        end else if (valid_i) begin
            unique case (state_q)
                S_HUNT: begin
                    if (data_i == SYNC_WORD) state_d = S_HEADER;
                end
                S_HEADER: begin
                    if (data_i[31:16] != HDR_MAGIC) begin
                        state_d = S_ERROR;
                        code_d  = ERR_MAGIC;
                    end else if (data_i[15:0] == 16'd0 ||
                                 data_i[15:0] > MAX_WORDS) begin
                        state_d = S_ERROR;
                        code_d  = ERR_LEN;
                    end else begin
                        state_d = S_PAYLOAD;
                        len_d   = data_i[15:0];
                        cnt_d   = 16'd0;
`ifdef BITSTREAM_CRC_EN
                        crc_d   = CRC_INIT;
`endif
                    end
                end
                S_PAYLOAD: begin
                    valid_d = 1'b1;
                    data_d  = data_i;
                    cnt_d   = cnt_q + 16'd1;
`ifdef BITSTREAM_CRC_EN
                    crc_d   = crc_fold(crc_q, data_i);
                    if (last_word) state_d = S_CRC;
`else
                    if (last_word) state_d = S_DONE;
`endif
                end
`ifdef BITSTREAM_CRC_EN
                S_CRC: begin
                    if (data_i == crc_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERROR;
                        code_d  = ERR_CRC;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge fpga_clk_i or negedge fpga_rst_ni) begin
        if (!fpga_rst_ni) begin
            state_q <= S_HUNT;
            len_q   <= 16'd0;
            cnt_q   <= 16'd0;
            code_q  <= ERR_NONE;
            data_q  <= 32'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            // Status flags follow the next state so they move with the state register.
            busy_q  <= (state_d == S_HEADER) || (state_d == S_PAYLOAD)
`ifdef BITSTREAM_CRC_EN
                       || (state_d == S_CRC)
`endif
                       ;
            done_q  <= (state_d == S_DONE);
            error_q <= (state_d == S_ERROR);
        end
    end

`ifdef BITSTREAM_CRC_EN
    always_ff @(posedge fpga_clk_i or negedge fpga_rst_ni) begin
        if (!fpga_rst_ni) crc_q <= CRC_INIT;
        else              crc_q <= crc_d;
    end
`endif

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign error_code_o = code_q;

endmodule
